dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-ported data memory between the multi-cycle CPU core (requester 0) and a loader/debug port (requester 1).
- Arbitrates per cycle with round-robin fairness and supports short locked bursts.
- Muxes address, write data and write enable onto the memory.
- Returns registered read data with a one-cycle valid pulse.
- Sits between the core's data-access path and the data memory.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin per beat, short locked bursts,
// combinational grant/mux, registered per-requester read return.

module dmem_arb_rport #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             rvalid,
    output logic [WIDTH-1:0] rd
);
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rd     <= '0;
        end else begin
            rvalid <= fire;
            if (fire) rd <= mem_rd;
        end
    end
endmodule

module dmem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADR_W     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_req,
    input  logic             r0_we,
    input  logic             r0_lock,
    input  logic [ADR_W-1:0] r0_adr,
    input  logic [WIDTH-1:0] r0_wd,
    output logic             r0_gnt,
    output logic             r0_rvalid,
    output logic [WIDTH-1:0] r0_rd,
    input  logic             r1_req,
    input  logic             r1_we,
    input  logic             r1_lock,
    input  logic [ADR_W-1:0] r1_adr,
    input  logic [WIDTH-1:0] r1_wd,
    output logic             r1_gnt,
    output logic             r1_rvalid,
    output logic [WIDTH-1:0] r1_rd,
    output logic             mem_we,
    output logic [ADR_W-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             locked,
    output logic             owner
);
    localparam int NREQ = 2;
    localparam int CW   = $clog2(MAX_BURST) + 1;
    localparam logic [CW:0] MAX_B = (CW+1)'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                       state, state_d;
    logic [CW-1:0]                beat_cnt, cnt_d, eff_cnt;
    logic [CW:0]                  cnt_inc;
    logic                         last_grant;
    logic                         sel, sel_vld, hold;

    logic [NREQ-1:0]              req, we, lock, gnt, rvalid;
    logic [NREQ-1:0][ADR_W-1:0]   adr;
    logic [NREQ-1:0][WIDTH-1:0]   wd, rd;

    assign req  = {r1_req,  r0_req};
    assign we   = {r1_we,   r0_we};
    assign lock = {r1_lock, r0_lock};
    assign adr  = {r1_adr,  r0_adr};
    assign wd   = {r1_wd,   r0_wd};

    // An owner that drops req releases at once; the IDLE rules then apply this cycle.
    always_comb begin
        hold    = 1'b0;
        sel     = 1'b0;
        sel_vld = 1'b0;
        if (state == OWN0 && req[0]) begin
            hold = 1'b1; sel = 1'b0; sel_vld = 1'b1;
        end else if (state == OWN1 && req[1]) begin
            hold = 1'b1; sel = 1'b1; sel_vld = 1'b1;
        end else if (req[0] && req[1]) begin
            sel = ~last_grant; sel_vld = 1'b1;
        end else if (req[0]) begin
            sel = 1'b0; sel_vld = 1'b1;
        end else if (req[1]) begin
            sel = 1'b1; sel_vld = 1'b1;
        end
    end

    assign gnt    = {sel_vld & sel, sel_vld & ~sel};
    assign r0_gnt = gnt[0];
    assign r1_gnt = gnt[1];

    assign mem_we  = sel_vld & we[sel];
    assign mem_adr = sel_vld ? adr[sel] : '0;
    assign mem_wd  = sel_vld ? wd[sel]  : '0;

    // A fresh burst (including one picked up on fall-through) counts from zero.
    always_comb begin
        eff_cnt = hold ? beat_cnt : '0;
        cnt_inc = {1'b0, eff_cnt} + (CW+1)'(1);
        state_d = IDLE;
        cnt_d   = '0;
        if (sel_vld && lock[sel] && (cnt_inc < MAX_B)) begin
            state_d = sel ? OWN1 : OWN0;
            cnt_d   = cnt_inc[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            state    <= state_d;
            beat_cnt <= cnt_d;
            if (sel_vld) begin
                last_grant <= sel;
                owner      <= sel;
            end
        end
    end

    assign locked = (state != IDLE);

    for (genvar i = 0; i < NREQ; i++) begin : g_rport
        dmem_arb_rport #(.WIDTH(WIDTH)) u_rport (
            .clk    (clk),
            .rst    (rst),
            .fire   (gnt[i] & ~we[i]),
            .mem_rd (mem_rd),
            .rvalid (rvalid[i]),
            .rd     (rd[i])
        );
    end

    assign r0_rvalid = rvalid[0];
    assign r1_rvalid = rvalid[1];
    assign r0_rd     = rd[0];
    assign r1_rd     = rd[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.

module tb_dmem_arbiter;
    localparam int WIDTH = 32;
    localparam int ADR_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [ADR_W-1:0] r0_adr, r1_adr;
    logic [WIDTH-1:0] r0_wd, r1_wd;
    logic             r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [WIDTH-1:0] r0_rd, r1_rd;
    logic             mem_we, locked, owner;
    logic [ADR_W-1:0] mem_adr;
    logic [WIDTH-1:0] mem_wd, mem_rd;

    logic [WIDTH-1:0] mem [0:255];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(WIDTH), .ADR_W(ADR_W), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_adr(r0_adr), .r0_wd(r0_wd),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rd(r0_rd),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_adr(r1_adr), .r1_wd(r1_wd),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rd(r1_rd),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .locked(locked), .owner(owner)
    );

    assign mem_rd = mem[mem_adr[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        mem[8'h10] <= 32'hDEADBEEF;
    end

    always @(posedge clk) if (mem_we) mem[mem_adr[7:0]] <= mem_wd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_adr = '0; r0_wd = '0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_adr = '0; r1_wd = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // reset state
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_owner",  64'(owner), 64'd0);
        chk("rst_r0_rv",  64'(r0_rvalid), 64'd0);
        chk("rst_r1_rv",  64'(r1_rvalid), 64'd0);
        chk("rst_r0_rd",  64'(r0_rd), 64'd0);
        @(negedge clk);
        chk("idle_gnt",   64'({r1_gnt, r0_gnt}), 64'd0);
        chk("idle_we",    64'(mem_we), 64'd0);
        chk("idle_adr",   64'(mem_adr), 64'd0);

        // r0 single read
        tick();
        r0_req = 1; r0_adr = 32'h10;
        @(negedge clk);
        chk("rd_r0_gnt", 64'(r0_gnt), 64'd1);
        chk("rd_r1_gnt", 64'(r1_gnt), 64'd0);
        chk("rd_adr",    64'(mem_adr), 64'h10);
        chk("rd_we",     64'(mem_we), 64'd0);
        tick();
        r0_req = 0;
        chk("rd_rvalid", 64'(r0_rvalid), 64'd1);
        chk("rd_data",   64'(r0_rd), 64'hDEADBEEF);
        chk("rd_r1_rv",  64'(r1_rvalid), 64'd0);
        tick();
        chk("rd_rv_pulse", 64'(r0_rvalid), 64'd0);
        chk("rd_hold",     64'(r0_rd), 64'hDEADBEEF);

        // alternation from fresh reset: r0 first
        do_reset();
        r0_req = 1; r1_req = 1; r0_adr = 32'h10; r1_adr = 32'h10;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rr_r0_%0d", k), 64'(r0_gnt), 64'(k % 2 == 0));
            chk($sformatf("rr_r1_%0d", k), 64'(r1_gnt), 64'(k % 2 == 1));
            tick();
        end
        idle_inputs();

        // r1 write, then r0 reads it back
        r1_req = 1; r1_we = 1; r1_adr = 32'h20; r1_wd = 32'h12345678;
        @(negedge clk);
        chk("wr_gnt", 64'(r1_gnt), 64'd1);
        chk("wr_we",  64'(mem_we), 64'd1);
        chk("wr_wd",  64'(mem_wd), 64'h12345678);
        chk("wr_adr", 64'(mem_adr), 64'h20);
        tick();
        idle_inputs();
        chk("wr_no_rv", 64'(r1_rvalid), 64'd0);
        r0_req = 1; r0_adr = 32'h20;
        tick();
        idle_inputs();
        chk("wr_rb_rv",   64'(r0_rvalid), 64'd1);
        chk("wr_rb_data", 64'(r0_rd), 64'h12345678);

        // r1 locked burst of 4 with r0 pending; last_grant is r0 so r1 starts
        r1_req = 1; r1_lock = 1; r1_adr = 32'h10;
        r0_req = 1; r0_adr = 32'h20;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("bu_r1_%0d", k),  64'(r1_gnt), 64'(k <= 4));
            chk($sformatf("bu_r0_%0d", k),  64'(r0_gnt), 64'(k == 5));
            chk($sformatf("bu_lk_%0d", k),  64'(locked), 64'(k >= 2 && k <= 4));
            tick();
        end
        idle_inputs();
        chk("bu_owner", 64'(owner), 64'd0);

        // r0 locked, drops after beat 2 while r1 requests
        r0_req = 1; r0_lock = 1; r0_adr = 32'h10;
        @(negedge clk);
        chk("dr_b1_gnt", 64'(r0_gnt), 64'd1);
        tick();
        r1_req = 1; r1_adr = 32'h20;
        @(negedge clk);
        chk("dr_b2_r0", 64'(r0_gnt), 64'd1);
        chk("dr_b2_r1", 64'(r1_gnt), 64'd0);
        chk("dr_b2_lk", 64'(locked), 64'd1);
        tick();
        r0_req = 0;
        @(negedge clk);
        chk("dr_r1_gnt", 64'(r1_gnt), 64'd1);
        chk("dr_r0_gnt", 64'(r0_gnt), 64'd0);
        chk("dr_mem_adr", 64'(mem_adr), 64'h20);
        tick();
        idle_inputs();
        chk("dr_unlock", 64'(locked), 64'd0);
        chk("dr_owner",  64'(owner), 64'd1);
        chk("dr_r1_rv",  64'(r1_rvalid), 64'd1);
        chk("dr_r1_rd",  64'(r1_rd), 64'h12345678);

        // reset mid-operation
        r0_req = 1; r0_lock = 1; r0_adr = 32'h10;
        @(negedge clk);
        chk("mr_gnt", 64'(r0_gnt), 64'd1);
        tick();
        chk("mr_pre_lk", 64'(locked), 64'd1);
        rst = 1; idle_inputs();
        tick();
        rst = 0;
        chk("mr_rv",     64'(r0_rvalid), 64'd0);
        chk("mr_rd",     64'(r0_rd), 64'd0);
        chk("mr_locked", 64'(locked), 64'd0);
        chk("mr_owner",  64'(owner), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
